// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the write-side FIFO control blocks:
// arbiter state encoding and a width helper.
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// found when searching upward from ptr+1, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;

    // Rotate so bit k of rotated is requester (ptr+1+k) mod NREQ.
    assign doubled = {req, req};
    assign rotated = NREQ'(doubled >> (32'(ptr) + 32'd1));

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                idx   = PTR_W'((32'(ptr) + 32'd1 + 32'(k)) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters,
// granting bounded bursts and never writing while the FIFO reports full.
module fifo_write_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DATASIZE = 8,
    parameter  int MAXBURST = 4,
    localparam int OWN_W    = clog2(NREQ),
    localparam int CNT_W    = (clog2(MAXBURST) < 1) ? 1 : clog2(MAXBURST)
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] wdata_in,
    output logic [NREQ-1:0]          gnt,
    input  logic                     full,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [OWN_W-1:0]         owner,
    output logic                     busy
);

    state_t               state;
    logic [OWN_W-1:0]     last;
    logic [CNT_W-1:0]     cnt;
    logic [OWN_W-1:0]     pick_ptr;
    logic [OWN_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 transfer;
    logic                 release_now;
    logic [DATASIZE-1:0]  lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = wdata_in[i*DATASIZE +: DATASIZE];
    end

    // Searching from owner+1 visits the owner last, so it is only re-picked
    // when no other requester is waiting.
    assign pick_ptr = (state == ST_GRANT) ? owner : last;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (OWN_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant is combinational so that full blocks the write in the same cycle.
    always_comb begin
        gnt = '0;
        if (state == ST_GRANT && req[owner] && !full) gnt[owner] = 1'b1;
    end

    assign winc        = |gnt;
    assign wdata       = lane[owner];
    assign busy        = (state == ST_GRANT);
    assign transfer    = winc;
    assign release_now = (transfer && cnt == CNT_W'(MAXBURST - 1)) || !req[owner];

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= OWN_W'(NREQ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state <= ST_GRANT;
                        owner <= pick_idx;
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        last <= owner;
                        cnt  <= '0;
                        if (pick_found) owner <= pick_idx;
                        else            state <= ST_IDLE;
                    end else if (transfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural arbitration model.
module tb_fifo_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DATASIZE = 8;
    localparam int MAXBURST = 4;

    typedef logic [DATASIZE-1:0] word_q_t[$];

    logic                     wclk;
    logic                     wrst_n;
    logic [NREQ-1:0]          req;
    logic [NREQ*DATASIZE-1:0] wdata_in;
    logic [NREQ-1:0]          gnt;
    logic                     full;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [1:0]               owner;
    logic                     busy;

    fifo_write_arbiter #(
        .NREQ     (NREQ),
        .DATASIZE (DATASIZE),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .wdata_in (wdata_in),
        .gnt      (gnt),
        .full     (full),
        .winc     (winc),
        .wdata    (wdata),
        .owner    (owner),
        .busy     (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // Requester side: each requester presents the head of its word queue.
    word_q_t words [NREQ];
    bit      full_drv = 1'b0;
    bit      rst_drv  = 1'b1;
    bit      rand_en  = 1'b0;
    int      pushed_total = 0;
    int      winc_total   = 0;
    int      winc_count   = 0;
    int      obs_gnt [NREQ];
    int      wr_owner[$];

    // Reference model of the arbitration rules.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rrFirst(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_cnt   = 0;
    endtask

    task automatic pushWord(input int i, input logic [DATASIZE-1:0] v);
        words[i].push_back(v);
        pushed_total++;
    endtask

    task automatic clearObs();
        winc_count = 0;
        wr_owner.delete();
        for (int i = 0; i < NREQ; i++) obs_gnt[i] = 0;
    endtask

    // One call = ncyc clock cycles; entered and left just after a rising edge.
    task automatic applyStimulus(input int ncyc);
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] others;
        logic [NREQ-1:0] exp_gnt;
        bit              f;
        bit              rn;
        bit              xfer;
        bit              rel;
        for (int c = 0; c < ncyc; c++) begin
            if (rand_en) begin
                if ($urandom_range(0, 2) == 0)
                    pushWord(int'($urandom_range(0, NREQ - 1)), DATASIZE'($urandom));
                full_drv = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                r[i] = (words[i].size() != 0);
                wdata_in[i*DATASIZE +: DATASIZE] = r[i] ? words[i][0] : DATASIZE'($urandom);
            end
            req    = r;
            full   = full_drv;
            wrst_n = rst_drv;
            f      = full_drv;
            rn     = rst_drv;
            xfer    = m_busy && r[m_owner] && !f;
            exp_gnt = xfer ? (NREQ'(1) << m_owner) : '0;

            @(negedge wclk);
            checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
            checkOutput("winc", 32'(winc), 32'(xfer));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("no_winc_while_full", 32'(winc & full), 32'd0);
            checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (m_busy) checkOutput("owner", 32'(owner), 32'(m_owner));
            if (xfer)   checkOutput("wdata_order", 32'(wdata), 32'(words[m_owner][0]));
            if (winc === 1'b1) begin
                winc_count++;
                winc_total++;
                wr_owner.push_back(int'(owner));
            end
            for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) obs_gnt[i]++;

            @(posedge wclk);
            if (xfer) void'(words[m_owner].pop_front());
            if (!rn) begin
                modelReset();
            end else if (!m_busy) begin
                if (r != '0) begin
                    m_busy  = 1'b1;
                    m_owner = rrFirst(r, m_last);
                    m_cnt   = 0;
                end
            end else begin
                rel = (xfer && m_cnt == MAXBURST - 1) || !r[m_owner];
                if (rel) begin
                    m_last = m_owner;
                    m_cnt  = 0;
                    others = r;
                    others[m_owner] = 1'b0;
                    if (others != '0)     m_owner = rrFirst(others, m_owner);
                    else if (!r[m_owner]) m_busy  = 1'b0;
                end else if (xfer) begin
                    m_cnt++;
                end
            end
            #1;
        end
    endtask

    function automatic bit allEmpty();
        for (int i = 0; i < NREQ; i++) if (words[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drainAll();
        int guard;
        guard = 0;
        full_drv = 1'b0;
        while (!allEmpty() && guard < 500) begin
            applyStimulus(1);
            guard++;
        end
        applyStimulus(2);
        checkOutput("drain_empty", 32'(allEmpty()), 32'd1);
        checkOutput("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic resetCycle();
        rst_drv = 1'b0;
        applyStimulus(1);
        rst_drv = 1'b1;
    endtask

    initial begin
        req      = '0;
        full     = 1'b0;
        wrst_n   = 1'b0;
        wdata_in = '0;
        @(posedge wclk);
        #1;
        modelReset();

        // Reset state, then one requester streaming 8 words.
        resetCycle();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_winc", 32'(winc), 32'd0);
        for (int k = 0; k < 8; k++) pushWord(0, DATASIZE'(8'h10 + k));
        clearObs();
        applyStimulus(9);
        checkOutput("s1_winc_count", 32'(winc_count), 32'd8);
        drainAll();

        // All four requesting: bursts of 4 in order 0,1,2,3,0 with no bubbles.
        resetCycle();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++) pushWord(i, DATASIZE'($urandom));
        clearObs();
        applyStimulus(21);
        checkOutput("s2_writes", 32'(wr_owner.size()), 32'd20);
        if (wr_owner.size() == 20) begin
            for (int b = 0; b < 5; b++) begin
                checkOutput("s2_burst_first", 32'(wr_owner[b*4]), 32'(b % NREQ));
                checkOutput("s2_burst_last", 32'(wr_owner[b*4+3]), 32'(b % NREQ));
            end
        end
        drainAll();

        // Owner 2 stalled by full mid-burst, then finishes and hands to 3.
        resetCycle();
        for (int k = 0; k < 4; k++) pushWord(2, DATASIZE'($urandom));
        for (int k = 0; k < 2; k++) pushWord(3, DATASIZE'($urandom));
        clearObs();
        applyStimulus(3);
        checkOutput("s3_pre_full_writes", 32'(winc_count), 32'd2);
        full_drv = 1'b1;
        clearObs();
        applyStimulus(5);
        checkOutput("s3_full_no_writes", 32'(winc_count), 32'd0);
        checkOutput("s3_owner_hold", 32'(owner), 32'd2);
        full_drv = 1'b0;
        clearObs();
        applyStimulus(2);
        checkOutput("s3_resume_writes", 32'(winc_count), 32'd2);
        checkOutput("s3_next_owner", 32'(owner), 32'd3);
        drainAll();

        // Requester 1 leaves after one word; pending requester 3 takes over.
        resetCycle();
        pushWord(1, DATASIZE'($urandom));
        for (int k = 0; k < 3; k++) pushWord(3, DATASIZE'($urandom));
        clearObs();
        applyStimulus(3);
        checkOutput("s4_owner", 32'(owner), 32'd3);
        checkOutput("s4_busy", 32'(busy), 32'd1);
        checkOutput("s4_req1_words", 32'(obs_gnt[1]), 32'd1);
        drainAll();

        // Reset in the middle of owner 3's burst restarts arbitration at 0.
        resetCycle();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) pushWord(i, DATASIZE'($urandom));
        applyStimulus(15);
        checkOutput("s5_owner_before", 32'(owner), 32'd3);
        resetCycle();
        checkOutput("s5_busy_after_reset", 32'(busy), 32'd0);
        checkOutput("s5_gnt_after_reset", 32'(gnt), 32'd0);
        applyStimulus(1);
        checkOutput("s5_regrant_owner", 32'(owner), 32'd0);
        checkOutput("s5_regrant_busy", 32'(busy), 32'd1);
        drainAll();

        // Random arrivals and random full stalls.
        resetCycle();
        rand_en = 1'b1;
        applyStimulus(300);
        rand_en = 1'b0;
        drainAll();

        checkOutput("total_words_written", 32'(winc_total), 32'(pushed_total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
